// File: rtl/cache_axi_pkg.sv
// Shared types and AXI encodings for the cache-to-AXI4 memory bridge.
// The optional AXI_ERR_CHECK_EN macro (used in cache_axi_master) enables response checking.
package cache_axi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WB,
      ST_AW,
      ST_W,
      ST_B,
      ST_AR,
      ST_R,
      ST_LD
   } axi_st_e;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_line_buffer.sv
// One cache line of storage: whole-line write for write-backs, per-word write for
// read beats, per-word read for write beats and a whole-line view for the load return.
module axi_line_buffer #(
   parameter  int DATA_SIZE  = 32,
   parameter  int BLOCK_SIZE = 6,
   localparam int BLOCKS     = 1 << BLOCK_SIZE
) (
   input  logic                              clk,
   input  logic                              line_we,
   input  logic [BLOCKS-1:0][DATA_SIZE-1:0]  line_wdata,
   input  logic                              word_we,
   input  logic [BLOCK_SIZE-1:0]             wr_idx,
   input  logic [DATA_SIZE-1:0]              word_wdata,
   input  logic [BLOCK_SIZE-1:0]             rd_idx,
   output logic [DATA_SIZE-1:0]              rd_data,
   output logic [BLOCKS-1:0][DATA_SIZE-1:0]  line_rdata
);

   // Contents are deliberately not reset; only valid data is ever presented.
   logic [BLOCKS-1:0][DATA_SIZE-1:0] mem;

   always_ff @(posedge clk) begin
      if (line_we)
         mem <= line_wdata;
      else if (word_we)
         mem[wr_idx] <= word_wdata;
   end

   assign rd_data    = mem[rd_idx];
   assign line_rdata = mem;

endmodule

// File: rtl/cache_axi_master.sv
// Cache block interface to AXI4 bridge: each write-back or load becomes one INCR burst.
// Define AXI_ERR_CHECK_EN to enable the sticky err flag on bad responses / rlast misplacement.
module cache_axi_master
   import cache_axi_pkg::*;
#(
   parameter  int ADDR_SIZE  = 32,
   parameter  int DATA_SIZE  = 32,
   parameter  int BLOCK_SIZE = 6,
   localparam int BLOCKS     = 1 << BLOCK_SIZE
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              addr_valid,
   input  logic [ADDR_SIZE-1:0]              addr,
   input  logic                              rw,
   output logic                              busy,
   output logic                              ready_wb,
   input  logic                              valid_wb,
   input  logic [BLOCKS-1:0][DATA_SIZE-1:0]  data_wb,
   output logic                              valid_ld,
   output logic [BLOCKS-1:0][DATA_SIZE-1:0]  data_ld,
   input  logic                              ready_ld,
   output logic [ADDR_SIZE-1:0]              awaddr,
   output logic [7:0]                        awlen,
   output logic [2:0]                        awsize,
   output logic [1:0]                        awburst,
   output logic                              awvalid,
   input  logic                              awready,
   output logic [DATA_SIZE-1:0]              wdata,
   output logic [DATA_SIZE/8-1:0]            wstrb,
   output logic                              wlast,
   output logic                              wvalid,
   input  logic                              wready,
   input  logic [1:0]                        bresp,
   input  logic                              bvalid,
   output logic                              bready,
   output logic [ADDR_SIZE-1:0]              araddr,
   output logic [7:0]                        arlen,
   output logic [2:0]                        arsize,
   output logic [1:0]                        arburst,
   output logic                              arvalid,
   input  logic                              arready,
   input  logic [DATA_SIZE-1:0]              rdata,
   input  logic [1:0]                        rresp,
   input  logic                              rlast,
   input  logic                              rvalid,
   output logic                              rready,
   output logic                              err,
   output logic [2:0]                        dbg_state
);

   // Handshakes: a transfer happens on a clock edge where valid && ready are both high;
   // every valid this block drives is decoded from state, so it holds until its handshake.
   localparam int                    SZ       = $clog2(DATA_SIZE / 8);
   localparam logic [BLOCK_SIZE-1:0] CNT_LAST = '1;

   axi_st_e                 state, state_nx;
   logic [ADDR_SIZE-1:0]    addr_q;
   logic [BLOCK_SIZE-1:0]   cnt;
   logic [ADDR_SIZE-1:0]    burst_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      ready_wb = 1'b0;
      awvalid  = 1'b0;
      wvalid   = 1'b0;
      bready   = 1'b0;
      arvalid  = 1'b0;
      rready   = 1'b0;
      valid_ld = 1'b0;
      busy     = (state != ST_IDLE);
      case (state)
         ST_IDLE: if (addr_valid) state_nx = rw ? ST_WB : ST_AR;
         ST_WB: begin
            ready_wb = 1'b1;
            if (valid_wb) state_nx = ST_AW;
         end
         ST_AW: begin
            awvalid = 1'b1;
            if (awready) state_nx = ST_W;
         end
         ST_W: begin
            wvalid = 1'b1;
            if (wready && cnt == CNT_LAST) state_nx = ST_B;
         end
         ST_B: begin
            bready = 1'b1;
            if (bvalid) state_nx = ST_IDLE;
         end
         ST_AR: begin
            arvalid = 1'b1;
            if (arready) state_nx = ST_R;
         end
         ST_R: begin
            // The beat counter, not rlast, decides when the line is complete.
            rready = 1'b1;
            if (rvalid && cnt == CNT_LAST) state_nx = ST_LD;
         end
         ST_LD: begin
            valid_ld = 1'b1;
            if (ready_ld) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Address and beat counter carry no reset so the AXI payload holds its last value.
   always_ff @(posedge clk) begin
      if (state == ST_IDLE && addr_valid)
         addr_q <= addr;
      if ((state == ST_AW && awready) || (state == ST_AR && arready))
         cnt <= '0;
      else if ((state == ST_W && wready) || (state == ST_R && rvalid))
         cnt <= cnt + 1'b1;
   end

   assign burst_addr = (addr_q & ~ADDR_SIZE'(BLOCKS - 1)) << SZ;

   axi_line_buffer #(
      .DATA_SIZE  (DATA_SIZE),
      .BLOCK_SIZE (BLOCK_SIZE)
   ) u_buf (
      .clk        (clk),
      .line_we    (state == ST_WB && valid_wb),
      .line_wdata (data_wb),
      .word_we    (state == ST_R && rvalid),
      .wr_idx     (cnt),
      .word_wdata (rdata),
      .rd_idx     (cnt),
      .rd_data    (wdata),
      .line_rdata (data_ld)
   );

   assign awaddr    = burst_addr;
   assign araddr    = burst_addr;
   assign awlen     = 8'(BLOCKS - 1);
   assign arlen     = 8'(BLOCKS - 1);
   assign awsize    = 3'(SZ);
   assign arsize    = 3'(SZ);
   assign awburst   = AXI_BURST_INCR;
   assign arburst   = AXI_BURST_INCR;
   assign wstrb     = '1;
   assign wlast     = (state == ST_W) && (cnt == CNT_LAST);
   assign dbg_state = state;

`ifdef AXI_ERR_CHECK_EN
   logic err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_q <= 1'b0;
      else if ((state == ST_B && bvalid && bresp != AXI_RESP_OKAY) ||
               (state == ST_R && rvalid &&
                (rresp != AXI_RESP_OKAY || rlast != (cnt == CNT_LAST))))
         err_q <= 1'b1;
   end

   assign err = err_q;
`else
   logic unused_resp;
   assign unused_resp = ^{bresp, rresp, rlast};
   assign err         = 1'b0;
`endif

endmodule
